// File: rtl/wb_arbiter.sv
// Writeback arbiter for the RV32 register file: per-source result FIFOs for ALU and LSU,
// alternating-priority arbitration, a registered writeback packet and a pending-write busy mask.

package rv32_wb_pkg;
    typedef struct packed {
        logic        wb_en;
        logic [4:0]  wb_sel;
        logic [31:0] wb_data;
    } rv32_writeback_packet_t;
endpackage

module wb_arbiter
    import rv32_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [4:0]                 lsu_rd,
    input  logic [31:0]                lsu_data,
    output rv32_writeback_packet_t     writeback_packet,
    output logic [$clog2(DEPTH):0]     alu_count,
    output logic [$clog2(DEPTH):0]     lsu_count,
    output logic [31:0]                busy_mask
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Handshake: a result transfers on a rising edge where valid && ready. ready depends only on
    // registered occupancy (never on valid or on a same-cycle pop), so a full FIFO stays closed
    // in the cycle it drains. Producers hold rd/data stable while valid && !ready.

    logic [4:0]    alu_rd_q   [DEPTH];
    logic [31:0]   alu_data_q [DEPTH];
    logic [4:0]    lsu_rd_q   [DEPTH];
    logic [31:0]   lsu_data_q [DEPTH];

    logic [AW-1:0] alu_wptr;
    logic [AW-1:0] alu_rptr;
    logic [AW-1:0] lsu_wptr;
    logic [AW-1:0] lsu_rptr;
    logic          last_grant_lsu;

    logic          alu_push;
    logic          lsu_push;
    logic          alu_pop;
    logic          lsu_pop;
    logic          alu_nonempty;
    logic          lsu_nonempty;
    logic [31:0]   busy_next;

    function automatic logic entry_live(input int idx, input logic [AW-1:0] rptr,
                                        input logic [CW-1:0] count);
        logic [AW-1:0] off;
        off = AW'(idx) - rptr;
        return {1'b0, off} < count;
    endfunction

    assign alu_ready    = !reset && (alu_count < FULL);
    assign lsu_ready    = !reset && (lsu_count < FULL);

    // x0 results complete the handshake but are dropped here.
    assign alu_push     = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign lsu_push     = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

    assign alu_nonempty = (alu_count != '0);
    assign lsu_nonempty = (lsu_count != '0);

    always_comb begin
        alu_pop = 1'b0;
        lsu_pop = 1'b0;
        if (alu_nonempty && (!lsu_nonempty || last_grant_lsu)) begin
            alu_pop = 1'b1;
        end else if (lsu_nonempty) begin
            lsu_pop = 1'b1;
        end
    end

    // Entries present next cycle are all current FIFO entries (a popped head moves into the
    // output register) plus whatever is accepted this cycle; the current output retires.
    always_comb begin
        busy_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_live(i, alu_rptr, alu_count)) begin
                busy_next[alu_rd_q[i]] = 1'b1;
            end
            if (entry_live(i, lsu_rptr, lsu_count)) begin
                busy_next[lsu_rd_q[i]] = 1'b1;
            end
        end
        if (alu_push) begin
            busy_next[alu_rd] = 1'b1;
        end
        if (lsu_push) begin
            busy_next[lsu_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_rd_q[alu_wptr]   <= alu_rd;
            alu_data_q[alu_wptr] <= alu_data;
        end
        if (lsu_push) begin
            lsu_rd_q[lsu_wptr]   <= lsu_rd;
            lsu_data_q[lsu_wptr] <= lsu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_wptr         <= '0;
            alu_rptr         <= '0;
            alu_count        <= '0;
            lsu_wptr         <= '0;
            lsu_rptr         <= '0;
            lsu_count        <= '0;
            last_grant_lsu   <= 1'b1;
            writeback_packet <= '0;
            busy_mask        <= '0;
        end else begin
            if (alu_push) begin
                alu_wptr <= alu_wptr + 1'b1;
            end
            if (alu_pop) begin
                alu_rptr <= alu_rptr + 1'b1;
            end
            case ({alu_push, alu_pop})
                2'b10:   alu_count <= alu_count + 1'b1;
                2'b01:   alu_count <= alu_count - 1'b1;
                default: alu_count <= alu_count;
            endcase

            if (lsu_push) begin
                lsu_wptr <= lsu_wptr + 1'b1;
            end
            if (lsu_pop) begin
                lsu_rptr <= lsu_rptr + 1'b1;
            end
            case ({lsu_push, lsu_pop})
                2'b10:   lsu_count <= lsu_count + 1'b1;
                2'b01:   lsu_count <= lsu_count - 1'b1;
                default: lsu_count <= lsu_count;
            endcase

            if (alu_pop) begin
                last_grant_lsu   <= 1'b0;
                writeback_packet <= '{wb_en: 1'b1, wb_sel: alu_rd_q[alu_rptr],
                                      wb_data: alu_data_q[alu_rptr]};
            end else if (lsu_pop) begin
                last_grant_lsu   <= 1'b1;
                writeback_packet <= '{wb_en: 1'b1, wb_sel: lsu_rd_q[lsu_rptr],
                                      wb_data: lsu_data_q[lsu_rptr]};
            end else begin
                writeback_packet <= '0;
            end

            busy_mask <= busy_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed test-plan steps then randomized traffic,
// compared every cycle against a queue-based reference model.

module tb_wb_arbiter;
    import rv32_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   alu_valid;
    logic                   alu_ready;
    logic [4:0]             alu_rd;
    logic [31:0]            alu_data;
    logic                   lsu_valid;
    logic                   lsu_ready;
    logic [4:0]             lsu_rd;
    logic [31:0]            lsu_data;
    rv32_writeback_packet_t writeback_packet;
    logic [CW-1:0]          alu_count;
    logic [CW-1:0]          lsu_count;
    logic [31:0]            busy_mask;

    // clock / reset
    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .alu_valid        (alu_valid),
        .alu_ready        (alu_ready),
        .alu_rd           (alu_rd),
        .alu_data         (alu_data),
        .lsu_valid        (lsu_valid),
        .lsu_ready        (lsu_ready),
        .lsu_rd           (lsu_rd),
        .lsu_data         (lsu_data),
        .writeback_packet (writeback_packet),
        .alu_count        (alu_count),
        .lsu_count        (lsu_count),
        .busy_mask        (busy_mask)
    );

    int checks   = 0;
    int errors   = 0;
    int wb_count = 0;

    // reference model: per-source queues of {rd, data}, expected output and busy set
    logic [36:0] m_alu[$];
    logic [36:0] m_lsu[$];
    logic        m_last_alu;
    logic [37:0] m_wb;
    logic [31:0] m_busy;

    // scoreboard: writes the model has granted but the DUT has not yet emitted
    logic [36:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = '0;
        foreach (m_alu[i]) m[m_alu[i][36:32]] = 1'b1;
        foreach (m_lsu[i]) m[m_lsu[i][36:32]] = 1'b1;
        if (m_wb[37]) m[m_wb[36:32]] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic model_edge();
        logic [36:0] e;
        bit a_ok;
        bit l_ok;
        if (reset) begin
            m_alu.delete();
            m_lsu.delete();
            exp_q.delete();
            m_last_alu = 1'b0;
            m_wb       = '0;
        end else begin
            a_ok = (m_alu.size() < DEPTH);
            l_ok = (m_lsu.size() < DEPTH);
            if (m_alu.size() > 0 && (m_lsu.size() == 0 || !m_last_alu)) begin
                e = m_alu.pop_front();
                m_wb = {1'b1, e};
                m_last_alu = 1'b1;
                exp_q.push_back(e);
            end else if (m_lsu.size() > 0) begin
                e = m_lsu.pop_front();
                m_wb = {1'b1, e};
                m_last_alu = 1'b0;
                exp_q.push_back(e);
            end else begin
                m_wb = '0;
            end
            if (alu_valid && a_ok && alu_rd != 5'd0) m_alu.push_back({alu_rd, alu_data});
            if (lsu_valid && l_ok && lsu_rd != 5'd0) m_lsu.push_back({lsu_rd, lsu_data});
        end
        m_busy = model_busy();
    endtask

    task automatic check_all();
        chk("wb_packet", writeback_packet, m_wb);
        chk("alu_count", alu_count, m_alu.size());
        chk("lsu_count", lsu_count, m_lsu.size());
        chk("busy_mask", busy_mask, m_busy);
        chk("alu_ready", alu_ready, !reset && (m_alu.size() < DEPTH));
        chk("lsu_ready", lsu_ready, !reset && (m_lsu.size() < DEPTH));
        if (writeback_packet.wb_en) begin
            wb_count++;
            chk("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("sb_order", writeback_packet[36:0], exp_q.pop_front());
        end
    endtask

    task automatic cycle();
        #2;
        chk("ready_pre_alu", alu_ready, !reset && (m_alu.size() < DEPTH));
        chk("ready_pre_lsu", lsu_ready, !reset && (m_lsu.size() < DEPTH));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // driver tasks
    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle();
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    initial begin
        int ai;
        int li;
        int snap;
        bit a_hold;
        bit l_hold;
        logic          av;
        logic          lv;
        logic [4:0]    ard;
        logic [4:0]    lrd;
        logic [31:0]   ad;
        logic [31:0]   ld;
        logic [31:0]   busy_before;

        m_last_alu = 1'b0;
        m_wb       = '0;
        m_busy     = '0;

        // reset and idle
        do_reset(2);
        repeat (5) cycle();
        chk("idle_wb_en", writeback_packet.wb_en, 0);
        chk("idle_alu_ready", alu_ready, 1);
        chk("idle_lsu_ready", lsu_ready, 1);
        chk("idle_busy", busy_mask, 0);

        // single ALU write, latency 2
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        cycle();
        idle();
        chk("lat_busy_c1", busy_mask[5], 1);
        cycle();
        chk("lat_en_c2", writeback_packet.wb_en, 1);
        chk("lat_sel_c2", writeback_packet.wb_sel, 5);
        chk("lat_data_c2", writeback_packet.wb_data, 32'hDEADBEEF);
        chk("lat_busy_c2", busy_mask[5], 1);
        cycle();
        chk("lat_en_c3", writeback_packet.wb_en, 0);
        chk("lat_busy_c3", busy_mask, 0);

        // simultaneous arrival after reset: ALU wins the first tie
        do_reset(1);
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        cycle();
        idle();
        cycle();
        chk("tie_sel_c2", writeback_packet.wb_sel, 1);
        chk("tie_data_c2", writeback_packet.wb_data, 32'h11);
        cycle();
        chk("tie_sel_c3", writeback_packet.wb_sel, 2);
        chk("tie_data_c3", writeback_packet.wb_data, 32'h22);
        cycle();

        // sustained traffic from both sources
        do_reset(1);
        snap = wb_count;
        ai = 1;
        li = 1;
        for (int n = 0; n < 40 && (ai <= 6 || li <= 6); n++) begin
            drive(ai <= 6, 5'(ai), 32'hA0000000 | 32'(ai),
                  li <= 6, 5'(10 + li), 32'h50000000 | 32'(li));
            av = (ai <= 6) && (m_alu.size() < DEPTH);
            lv = (li <= 6) && (m_lsu.size() < DEPTH);
            cycle();
            if (av) ai++;
            if (lv) li++;
        end
        idle();
        repeat (3 * DEPTH + 4) cycle();
        chk("burst_writes", wb_count - snap, 12);
        chk("burst_drained", exp_q.size(), 0);

        // x0 destination is accepted and dropped
        busy_before = busy_mask;
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
        chk("x0_ready", alu_ready, 1);
        snap = wb_count;
        cycle();
        idle();
        chk("x0_count", alu_count, 0);
        chk("x0_busy", busy_mask, busy_before);
        repeat (3) cycle();
        chk("x0_no_write", wb_count - snap, 0);

        // reset discards queued work
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 5'(20 + n), 32'hC0DE0000 | 32'(n), 1'b1, 5'(24 + n), 32'hF00D0000 | 32'(n));
            cycle();
        end
        do_reset(1);
        idle();
        chk("rst_alu_count", alu_count, 0);
        chk("rst_lsu_count", lsu_count, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_wb_en", writeback_packet.wb_en, 0);
        snap = wb_count;
        repeat (8) cycle();
        chk("rst_no_write", wb_count - snap, 0);

        // randomized traffic with producer hold rule and occasional reset
        a_hold = 1'b0;
        l_hold = 1'b0;
        av = 1'b0; ard = '0; ad = '0;
        lv = 1'b0; lrd = '0; ld = '0;
        for (int n = 0; n < 500; n++) begin
            if (!a_hold) begin
                av  = ($urandom_range(0, 2) != 0);
                ard = 5'($urandom_range(0, 31));
                ad  = $urandom;
            end
            if (!l_hold) begin
                lv  = ($urandom_range(0, 2) != 0);
                lrd = 5'($urandom_range(0, 31));
                ld  = $urandom;
            end
            reset = ($urandom_range(0, 149) == 0);
            a_hold = av && (reset || m_alu.size() >= DEPTH);
            l_hold = lv && (reset || m_lsu.size() >= DEPTH);
            drive(av, ard, ad, lv, lrd, ld);
            cycle();
        end
        reset = 1'b0;
        idle();
        repeat (3 * DEPTH + 4) cycle();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_idle_busy", busy_mask, 0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
